cone_eval_arbiter: RTL and testbench



---
 rtl/cone_eval_arbiter.sv | 122 ++++++++++++
 tb/tb_cone_eval_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cone_eval_arbiter.sv
// Round-robin arbiter sharing one external logic cone among NREQ requesters.
// Optional response MISR on sig is enabled by defining CONE_EVAL_SIG_EN.
module cone_eval_arbiter #(
  parameter int NREQ = 4,
  parameter int NIN  = 25,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*NIN-1:0]  req_vec,
  output logic [NREQ-1:0]      req_ready,
  output logic [NIN-1:0]       cone_x,
  input  logic                 cone_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_y,
  output logic                 busy,
  output logic [15:0]          eval_cnt,
  output logic [15:0]          sig
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] idx;
  logic           gnt_any;
  logic           take;
  logic           done;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = last_q;
    for (int k = 0; k < NREQ; k++) begin
      if (idx == IDW'(NREQ - 1)) idx = '0;
      else                       idx = idx + 1'b1;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any && rst_n) begin
          take    = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = take ? (NREQ'(1) << gnt_idx)
                          : '0;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IDW'(NREQ - 1);
      cone_x   <= '0;
      rsp_id   <= '0;
      rsp_y    <= 1'b0;
      eval_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        cone_x <= req_vec[gnt_idx*NIN +: NIN];
        rsp_id <= gnt_idx;
        last_q <= gnt_idx;
      end
      if (state_q == EVAL) rsp_y <= cone_y;
      if (done) eval_cnt <= eval_cnt + 16'd1;
    end
  end

`ifdef CONE_EVAL_SIG_EN
  logic [15:0] sig_q;
  logic        fb;

  // CRC-16-CCITT style shift; folds rsp_y in on each accepted response.
  assign fb = sig_q[15] ^ rsp_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= 16'hFFFF;
    end else if (done) begin
      sig_q <= {sig_q[14:0], 1'b0}
             ^ (fb ? 16'h1021 : 16'h0000);
    end
  end

  assign sig = sig_q;
`else
  assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_cone_eval_arbiter.sv
// Testbench for cone_eval_arbiter: vector table, scoreboard and
// hand-written reset, fairness and backpressure sequences.
module tb_cone_eval_arbiter;

  localparam int NREQ = 4;
  localparam int NIN  = 25;
  localparam int IDW  = 2;

`ifdef CONE_EVAL_SIG_EN
  localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
  localparam logic [15:0] SIG_RST = 16'h0000;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NIN-1:0]      vecs [NREQ];
  logic [NREQ*NIN-1:0] req_vec;
  logic [NREQ-1:0]     req_ready;
  logic [NIN-1:0]      cone_x;
  logic                cone_y;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_y;
  logic                busy;
  logic [15:0]         eval_cnt;
  logic [15:0]         sig;

  assign req_vec = {vecs[3], vecs[2], vecs[1], vecs[0]};
  assign cone_y  = cone_x[0];

  always #5 clk = ~clk;

  cone_eval_arbiter #(
    .NREQ(NREQ),
    .NIN (NIN),
    .IDW (IDW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_vec  (req_vec),
    .req_ready(req_ready),
    .cone_x   (cone_x),
    .cone_y   (cone_y),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_y    (rsp_y),
    .busy     (busy),
    .eval_cnt (eval_cnt),
    .sig      (sig)
  );

  typedef struct packed {
    logic [3:0] mask;
    logic [3:0] ybits;
    logic [3:0] stall;
    logic [1:0] id;
    logic       y;
  } rec_t;

  typedef struct packed {
    logic [1:0] id;
    logic       y;
  } rsp_t;

  rsp_t        sb [$];
  rec_t        tbl [7];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  logic [15:0] m_sig;
  logic [15:0] m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s,
                                       input logic y);
    return {s[14:0], 1'b0} ^ ((s[15] ^ y) ? 16'h1021 : 16'h0000);
  endfunction

  // Pop the scoreboard and compare against the response on the bus.
  task automatic pop_rsp(input string nm);
    rsp_t e;
    chk({nm, " sb depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, " rsp_id"}, rsp_id, e.id);
      chk({nm, " rsp_y"}, rsp_y, e.y);
      m_cnt = m_cnt + 16'd1;
`ifdef CONE_EVAL_SIG_EN
      m_sig = misr(m_sig, e.y);
`endif
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_sig = SIG_RST;
    m_cnt = '0;
    sb.delete();
  endtask

  initial begin
    logic [31:0] tmp;
    logic [NIN-1:0] ev;
    rec_t tv;
    int k;
    int lastc;
    int nrsp;

    tbl[0] = '{4'hF, 4'b1011, 4'd0, 2'd0, 1'b1};
    tbl[1] = '{4'hF, 4'b1100, 4'd0, 2'd1, 1'b0};
    tbl[2] = '{4'h9, 4'b1000, 4'd5, 2'd3, 1'b1};
    tbl[3] = '{4'h3, 4'b0010, 4'd2, 2'd0, 1'b0};
    tbl[4] = '{4'h4, 4'b0100, 4'd0, 2'd2, 1'b1};
    tbl[5] = '{4'h3, 4'b0001, 4'd0, 2'd0, 1'b1};
    tbl[6] = '{4'hA, 4'b0010, 4'd1, 2'd1, 1'b1};

    for (int r = 0; r < NREQ; r++) begin
      tmp = $urandom();
      vecs[r] = tmp[NIN-1:0] | 25'h1;
    end

    // Reset with every requester asserting valid.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", req_ready, 0);
    chk("rst cone_x", cone_x, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_id", rsp_id, 0);
    chk("rst rsp_y", rsp_y, 0);
    chk("rst busy", busy, 0);
    chk("rst eval_cnt", eval_cnt, 0);
    chk("rst sig", sig, SIG_RST);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    m_sig     = SIG_RST;
    m_cnt     = '0;

    // Single request from requester 2.
    vecs[2]   = 25'h0000001;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single grant", req_ready, 4'b0100);
    sb.push_back('{2'd2, 1'b1});
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("single cone_x", cone_x, 25'h1);
    chk("single early valid", rsp_valid, 0);
    @(negedge clk);
    chk("single rsp_valid", rsp_valid, 1);
    pop_rsp("single");
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("single eval_cnt", eval_cnt, m_cnt);
    chk("single sig", sig, m_sig);
    chk("single busy", busy, 0);

    // Table of transactions, including stalled responses.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tv = tbl[i];
      for (int r = 0; r < NREQ; r++) begin
        tmp = $urandom();
        vecs[r] = {tmp[NIN-1:1], tv.ybits[r]};
      end
      req_valid = tv.mask;
      @(negedge clk);
      chk("tbl grant", req_ready, 4'b0001 << tv.id);
      ev = vecs[tv.id];
      sb.push_back('{tv.id, tv.y});
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      chk("tbl cone_x", cone_x, ev);
      chk("tbl eval busy", busy, 1);
      chk("tbl eval valid", rsp_valid, 0);
      @(negedge clk);
      chk("tbl rsp_valid", rsp_valid, 1);
      req_valid = 4'hF;
      for (int s = 0; s < int'(tv.stall); s++) begin
        #1;
        chk("stall valid", rsp_valid, 1);
        chk("stall id", rsp_id, tv.id);
        chk("stall y", rsp_y, tv.y);
        chk("stall req_ready", req_ready, 0);
        chk("stall busy", busy, 1);
        @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      pop_rsp("tbl");
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("tbl eval_cnt", eval_cnt, m_cnt);
      chk("tbl sig", sig, m_sig);
      chk("tbl done valid", rsp_valid, 0);
      @(posedge clk);
      #1;
    end

    // Continuous requests from everyone: fixed order, 3-cycle spacing.
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    k = 0;
    lastc = 0;
    for (int c = 0; c < 40 && !(k == 6 && sb.size() == 0); c++) begin
      @(negedge clk);
      if (rsp_valid) pop_rsp("rr");
      if (req_ready != 0) begin
        chk("rr grant", req_ready, 4'b0001 << (k % 4));
        if (k > 0) chk("rr spacing", cyc - lastc, 3);
        lastc = cyc;
        ev = vecs[k % 4];
        sb.push_back('{2'(k % 4), ev[0]});
        k++;
        if (k == 6) begin
          @(posedge clk);
          #1;
          req_valid = '0;
        end
      end
    end
    chk("rr grants", k, 6);
    chk("rr drained", sb.size(), 0);

    // Reset landing in EVAL discards the transaction.
    do_reset();
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid grant", req_ready, 4'b1000);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("mid eval busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("mid no rsp", nrsp, 0);
    chk("mid eval_cnt", eval_cnt, 0);
    chk("mid busy", busy, 0);
    chk("mid cone_x", cone_x, 0);
    chk("mid sig", sig, SIG_RST);
    req_valid = 4'hF;
    #1;
    chk("mid next grant", req_ready, 4'b0001);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
